// File: rtl/bht_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl_pkg
// Constants shared by the BHT update controller and the branch predictor:
// 2-bit counter encodings, the BHT index width, the PC bit range that forms
// the index (so both sides index identically) and the controller state
// encodings.
// -----------------------------------------------------------------------------
package bht_update_ctrl_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] STRONG_T  = 2'b11;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] STRONG_NT = 2'b00;

    // BHT geometry: index = pc[BHT_IDX_MSB:BHT_IDX_LSB]
    localparam int BHT_IDX_W   = 8;
    localparam int BHT_IDX_LSB = 2;
    localparam int BHT_IDX_MSB = BHT_IDX_W + BHT_IDX_LSB - 1;

    // Controller states
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bht_state_e;

endpackage

// File: rtl/bht_update_ctrl_evt_fifo.sv
// -----------------------------------------------------------------------------
// bp_evt_fifo
// Two-write / one-read FIFO of resolved-branch events. Write port 0 lands
// ahead of write port 1 when both fire in one cycle; if only port 1 fires it
// takes the tail slot. Callers must never write more than the free space.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (pointers/count)
//   wr0_en, wr0_data    older write
//   wr1_en, wr1_data    younger write
//   rd_en               pop the head entry
//   rd_data             head entry (valid when count != 0)
//   count               number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module bp_evt_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  wr1_ptr;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        // Port 1 follows port 0 only when port 0 actually wrote
        wr1_ptr = tail_q + PTR_W'(wr0_en);
        tail_d  = tail_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
        head_d  = head_q + PTR_W'(rd_en);
        count_d = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[tail_q]  <= wr0_data;
        if (wr1_en) mem_q[wr1_ptr] <= wr1_data;
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl
// Sequences every write into the 2-bit branch history table. After reset it
// sweeps all entries to STRONG_NT (one per rdy cycle), then accepts up to two
// committed branch outcomes per cycle into a small FIFO and drains them to
// the predictor's single update port, one per rdy cycle.
//
// Build option: define BP_STATS_EN to add saturating branch / mispredict
// counters (stat_branches, stat_mispred). Without it the c*_pred inputs are
// unused.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; low freezes all state
//   c0_*/c1_*                commit slots 0 (older) and 1 (younger)
//   commit_ready             >= 2 free FIFO slots and sweep complete
//   upd_valid/idx/taken      BHT training write
//   init_valid/init_idx      clear-to-STRONG_NT write during the sweep
//   bp_ready                 sweep complete, predictions usable
//   stat_branches/mispred    (BP_STATS_EN) event counters
// -----------------------------------------------------------------------------
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int IDX_W      = BHT_IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              c0_valid,
    input  logic [ADDR_W-1:0] c0_pc,
    input  logic              c0_taken,
    input  logic              c0_pred,
    input  logic              c1_valid,
    input  logic [ADDR_W-1:0] c1_pc,
    input  logic              c1_taken,
    input  logic              c1_pred,
    output logic              commit_ready,
    output logic              upd_valid,
    output logic [IDX_W-1:0]  upd_idx,
    output logic              upd_taken,
    output logic              init_valid,
    output logic [IDX_W-1:0]  init_idx,
    output logic              bp_ready
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef BP_STATS_EN
    localparam int ENT_W = IDX_W + 2;   // {idx, taken, pred}
`else
    localparam int ENT_W = IDX_W + 1;   // {idx, taken}
`endif

    bht_state_e        state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  ent0, ent1, head_ent;
    logic [IDX_W-1:0]  c0_idx, c1_idx;
    logic              push0, push1, pop;
    logic              unused_bits;

    assign c0_idx = c0_pc[IDX_W+BHT_IDX_LSB-1:BHT_IDX_LSB];
    assign c1_idx = c1_pc[IDX_W+BHT_IDX_LSB-1:BHT_IDX_LSB];

`ifdef BP_STATS_EN
    assign ent0 = {c0_idx, c0_taken, c0_pred};
    assign ent1 = {c1_idx, c1_taken, c1_pred};
    assign unused_bits = ^{c0_pc[ADDR_W-1:IDX_W+BHT_IDX_LSB], c0_pc[BHT_IDX_LSB-1:0],
                           c1_pc[ADDR_W-1:IDX_W+BHT_IDX_LSB], c1_pc[BHT_IDX_LSB-1:0],
                           head_ent[0]};
`else
    assign ent0 = {c0_idx, c0_taken};
    assign ent1 = {c1_idx, c1_taken};
    assign unused_bits = ^{c0_pc[ADDR_W-1:IDX_W+BHT_IDX_LSB], c0_pc[BHT_IDX_LSB-1:0],
                           c1_pc[ADDR_W-1:IDX_W+BHT_IDX_LSB], c1_pc[BHT_IDX_LSB-1:0],
                           c0_pred, c1_pred};
`endif

    // State register; rdy low freezes the sweep and the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        init_valid   = 1'b0;
        bp_ready     = 1'b0;
        commit_ready = 1'b0;
        upd_valid    = 1'b0;
        case (state_q)
            INIT: begin
                init_valid = 1'b1;
                // Index wraps back to 0 as the last entry is written
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q) state_d = RUN;
            end
            RUN: begin
                bp_ready     = 1'b1;
                commit_ready = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
                upd_valid    = (fifo_count != '0);
            end
            default: state_d = INIT;
        endcase
    end

    // Events offered while not ready are dropped here
    assign push0 = rdy && commit_ready && c0_valid;
    assign push1 = rdy && commit_ready && c1_valid;
    assign pop   = rdy && upd_valid;

    bp_evt_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (push0),
        .wr0_data (ent0),
        .wr1_en   (push1),
        .wr1_data (ent1),
        .rd_en    (pop),
        .rd_data  (head_ent),
        .count    (fifo_count)
    );

    assign upd_idx   = head_ent[ENT_W-1 -: IDX_W];
    assign upd_taken = head_ent[ENT_W-1-IDX_W];
    assign init_idx  = init_idx_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        stat_br_d = sat_add(stat_br_q, {1'b0, push0} + {1'b0, push1});
        stat_mp_d = sat_add(stat_mp_q, {1'b0, push0 && (c0_taken != c0_pred)}
                                     + {1'b0, push1 && (c1_taken != c1_pred)});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`endif

    // The ROB must hold commits while commit_ready is low
    a_no_commit_when_full: assert property (@(posedge clk) disable iff (rst)
        (rdy && !commit_ready) |-> !(c0_valid || c1_valid));

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        c0_valid, c0_taken, c0_pred;
    logic        c1_valid, c1_taken, c1_pred;
    logic [31:0] c0_pc, c1_pc;
    logic        commit_ready, upd_valid, upd_taken, init_valid, bp_ready;
    logic [7:0]  upd_idx, init_idx;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bht_update_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .c0_valid     (c0_valid),
        .c0_pc        (c0_pc),
        .c0_taken     (c0_taken),
        .c0_pred      (c0_pred),
        .c1_valid     (c1_valid),
        .c1_pc        (c1_pc),
        .c1_taken     (c1_taken),
        .c1_pred      (c1_pred),
        .commit_ready (commit_ready),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .init_valid   (init_valid),
        .init_idx     (init_idx),
        .bp_ready     (bp_ready)
`ifdef BP_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c0_valid = 1'b0; c0_pc = '0; c0_taken = 1'b0; c0_pred = 1'b0;
        c1_valid = 1'b0; c1_pc = '0; c1_taken = 1'b0; c1_pred = 1'b0;
    endtask

    task automatic drive(input logic v0, input logic [31:0] pc0, input logic t0, input logic p0,
                         input logic v1, input logic [31:0] pc1, input logic t1, input logic p1);
        c0_valid = v0; c0_pc = pc0; c0_taken = t0; c0_pred = p0;
        c1_valid = v1; c1_pc = pc1; c1_taken = t1; c1_pred = p1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear_inputs();
        tick(); tick();
        rst = 1'b0;
        checks++; if (init_valid !== 1'b1) begin errors++; $display("FAIL reset_init_valid: got %b want 1", init_valid); end
        checks++; if (init_idx !== 8'd0) begin errors++; $display("FAIL reset_init_idx: got %0d want 0", init_idx); end
        checks++; if (bp_ready !== 1'b0) begin errors++; $display("FAIL reset_bp_ready: got %b want 0", bp_ready); end
        checks++; if (commit_ready !== 1'b0) begin errors++; $display("FAIL reset_commit_ready: got %b want 0", commit_ready); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
`ifdef BP_STATS_EN
        checks++; if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin errors++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispred); end
`endif
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (init_idx !== 8'(i) || init_valid !== 1'b1 || commit_ready !== 1'b0 || bp_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep_cycle_%0d: idx=%0d iv=%b cr=%b bpr=%b want idx=%0d iv=1 cr=0 bpr=0",
                         i, init_idx, init_valid, commit_ready, bp_ready, i);
            end
            tick();
        end
        checks++; if (bp_ready !== 1'b1) begin errors++; $display("FAIL sweep_done_bp_ready: got %b want 1", bp_ready); end
        checks++; if (init_valid !== 1'b0) begin errors++; $display("FAIL sweep_done_init_valid: got %b want 0", init_valid); end
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL sweep_done_commit_ready: got %b want 1", commit_ready); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL sweep_done_upd_valid: got %b want 0", upd_valid); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h0000_1008, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'h02 || upd_taken !== 1'b1) begin errors++;
            $display("FAIL single_upd: v=%b idx=%h t=%b want v=1 idx=02 t=1", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL single_after: got upd_valid=%b want 0", upd_valid); end
    endtask

    task automatic test_dual();
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b0);
        tick();
        clear_inputs();
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'h40 || upd_taken !== 1'b0) begin errors++;
            $display("FAIL dual_first: v=%b idx=%h t=%b want v=1 idx=40 t=0", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'h81 || upd_taken !== 1'b1) begin errors++;
            $display("FAIL dual_second: v=%b idx=%h t=%b want v=1 idx=81 t=1", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL dual_after: got upd_valid=%b want 0", upd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_idx [6];
        logic       exp_tk  [6];
        int         sent, got, mcount, cyc;
        bit         saw_drop, popped;
        sent = 0; got = 0; mcount = 0; cyc = 0; saw_drop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_idx[i] = 8'h10 + 8'(i);
            exp_tk[i]  = i[0];
        end
        while ((sent < 3 || got < 6) && cyc < 40) begin
            checks++; if (commit_ready !== (mcount <= 2)) begin errors++;
                $display("FAIL b2b_commit_ready_cyc%0d: got %b want %b", cyc, commit_ready, (mcount <= 2)); end
            checks++; if (upd_valid !== (mcount != 0)) begin errors++;
                $display("FAIL b2b_upd_valid_cyc%0d: got %b want %b", cyc, upd_valid, (mcount != 0)); end
            if (commit_ready === 1'b0) saw_drop = 1'b1;
            popped = (upd_valid === 1'b1);
            if (popped) begin
                checks++;
                if (got >= 6) begin errors++; $display("FAIL b2b_extra_update: idx=%h want none", upd_idx); end
                else if (upd_idx !== exp_idx[got] || upd_taken !== exp_tk[got]) begin errors++;
                    $display("FAIL b2b_order_%0d: idx=%h t=%b want idx=%h t=%b", got, upd_idx, upd_taken, exp_idx[got], exp_tk[got]); end
                got++;
            end
            if (sent < 3 && commit_ready === 1'b1) begin
                drive(1'b1, {22'd0, exp_idx[2*sent], 2'b00}, exp_tk[2*sent], 1'b0,
                      1'b1, {22'd0, exp_idx[2*sent+1], 2'b00}, exp_tk[2*sent+1], 1'b0);
                mcount += 2;
                sent++;
            end else begin
                clear_inputs();
            end
            if (popped) mcount--;
            tick();
            cyc++;
        end
        clear_inputs();
        checks++; if (sent != 3 || got != 6) begin errors++;
            $display("FAIL b2b_timeout: sent=%0d drained=%0d want 3/6", sent, got); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got upd_valid=%b want 0", upd_valid); end
        checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: commit_ready never dropped, want drop"); end
    endtask

    task automatic test_rdy_freeze();
        drive(1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0308, 1'b1, 1'b0, 1'b1, 32'h0000_030C, 1'b1, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'hC0 || upd_taken !== 1'b1) begin errors++;
            $display("FAIL freeze_first: v=%b idx=%h t=%b want v=1 idx=c0 t=1", upd_valid, upd_idx, upd_taken); end
        tick();
        clear_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (upd_valid !== 1'b1 || upd_idx !== 8'hC1 || upd_taken !== 1'b0 || commit_ready !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold_%0d: v=%b idx=%h t=%b cr=%b want v=1 idx=c1 t=0 cr=0",
                         i, upd_valid, upd_idx, upd_taken, commit_ready);
            end
        end
        rdy = 1'b1;
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'hC1 || upd_taken !== 1'b0) begin errors++;
            $display("FAIL freeze_resume_1: v=%b idx=%h t=%b want v=1 idx=c1 t=0", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'hC2 || upd_taken !== 1'b1) begin errors++;
            $display("FAIL freeze_resume_2: v=%b idx=%h t=%b want v=1 idx=c2 t=1", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b1 || upd_idx !== 8'hC3 || upd_taken !== 1'b1) begin errors++;
            $display("FAIL freeze_resume_3: v=%b idx=%h t=%b want v=1 idx=c3 t=1", upd_valid, upd_idx, upd_taken); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL freeze_empty: got upd_valid=%b want 0", upd_valid); end
    endtask

    task automatic test_rst_mid_sweep();
        // Queue two events, then reset while they are still pending
        drive(1'b1, 32'h0000_03F0, 1'b1, 1'b0, 1'b1, 32'h0000_03F4, 1'b1, 1'b0);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (upd_valid !== 1'b0 || init_valid !== 1'b1 || init_idx !== 8'd0 || bp_ready !== 1'b0 || commit_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain: uv=%b iv=%b idx=%0d bpr=%b cr=%b want 0/1/0/0/0",
                     upd_valid, init_valid, init_idx, bp_ready, commit_ready);
        end
        repeat (100) tick();
        checks++; if (init_idx !== 8'd100) begin errors++; $display("FAIL rst_sweep_progress: got %0d want 100", init_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (init_idx !== 8'd0 || init_valid !== 1'b1) begin errors++;
            $display("FAIL rst_sweep_restart: idx=%0d iv=%b want 0/1", init_idx, init_valid); end
        repeat (255) tick();
        checks++; if (init_idx !== 8'd255 || bp_ready !== 1'b0) begin errors++;
            $display("FAIL rst_sweep_last: idx=%0d bpr=%b want 255/0", init_idx, bp_ready); end
        tick();
        checks++; if (bp_ready !== 1'b1 || upd_valid !== 1'b0) begin errors++;
            $display("FAIL rst_sweep_done: bpr=%b uv=%b want 1/0", bp_ready, upd_valid); end
`ifdef BP_STATS_EN
        checks++; if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin errors++;
            $display("FAIL stats_cleared: got %0d/%0d want 0/0", stat_branches, stat_mispred); end
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h0000_0018, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        checks++; if (stat_branches !== 32'd3) begin errors++; $display("FAIL stats_branches: got %0d want 3", stat_branches); end
        checks++; if (stat_mispred !== 32'd2) begin errors++; $display("FAIL stats_mispred: got %0d want 2", stat_mispred); end
        repeat (4) tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_rdy_freeze();
        test_rst_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
